// File: rtl/pcie_phy_pkg.sv
// pcie_phy_pkg: shared PHY constants and aligner state encoding
package pcie_phy_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COM_SYM = 8'hBC;
  typedef enum logic [1:0] {SEARCH = 2'd0, LOCKING = 2'd1, ACTIVE = 2'd2} align_state_e;
endpackage

// File: rtl/s2p_com_align.sv
// s2p_com_align: serial-to-parallel COM bit-hunt and byte aligner; `S2P_LOSS_DETECT_EN adds zero-byte loss of lock
module s2p_com_align
  import pcie_phy_pkg::*;
#(
  parameter int COM_COUNT  = 4,
  parameter int LOSS_COUNT = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              byte_strobe,
  output logic              active
);
  localparam logic [3:0] COM_N = 4'(COM_COUNT);
  align_state_e state_q, state_d;
  // only the 7 newest bits are ever needed to form the next byte window
  logic [BYTE_W-2:0] sr_q, sr_d;
  logic [BYTE_W-1:0] nxt, data_q, data_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic valid_q, valid_d, strobe_q, strobe_d, active_q, active_d, bnd;
`ifdef S2P_LOSS_DETECT_EN
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);
  logic [3:0] loss_cnt_q, loss_cnt_d;
`endif
  always_comb begin
    nxt       = {sr_q, data_in};
    bnd       = bit_cnt_q == 3'd7;
    sr_d      = nxt[BYTE_W-2:0];
    bit_cnt_d = bit_cnt_q + 3'd1;
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
    active_d  = active_q;
`ifdef S2P_LOSS_DETECT_EN
    loss_cnt_d = loss_cnt_q;
`endif
    case (state_q)
      SEARCH: if (nxt == COM_SYM) begin
        bit_cnt_d = 3'd0;
        com_cnt_d = 4'd1;
        state_d   = COM_N == 4'd1 ? ACTIVE : LOCKING;
        active_d  = COM_N == 4'd1;
      end
      LOCKING: if (bnd) begin
        if (nxt == COM_SYM) begin
          com_cnt_d = com_cnt_q + 4'd1;
          state_d   = com_cnt_d == COM_N ? ACTIVE : LOCKING;
          active_d  = com_cnt_d == COM_N;
        end else begin
          state_d   = SEARCH;
          com_cnt_d = 4'd0;
        end
      end
      ACTIVE: if (bnd) begin
        data_d   = nxt;
        valid_d  = nxt != COM_SYM;
        strobe_d = 1'b1;
`ifdef S2P_LOSS_DETECT_EN
        loss_cnt_d = nxt == '0 ? loss_cnt_q + 4'd1 : 4'd0;
        if (loss_cnt_d == LOSS_N) begin
          state_d    = SEARCH;
          active_d   = 1'b0;
          valid_d    = 1'b0;
          loss_cnt_d = 4'd0;
          com_cnt_d  = 4'd0;
        end
`endif
      end
      default: state_d = SEARCH;
    endcase
  end
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q   <= SEARCH;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
`ifdef S2P_LOSS_DETECT_EN
      loss_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      active_q  <= active_d;
`ifdef S2P_LOSS_DETECT_EN
      loss_cnt_q <= loss_cnt_d;
`endif
    end
  end
  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;
endmodule

// File: tb/tb_s2p_com_align.sv
// tb_s2p_com_align: directed table-driven bench for the COM byte aligner
module tb_s2p_com_align;
  logic clk_32f = 1'b0, reset = 1'b1, data_in = 1'b0;
  logic [7:0] data_out;
  logic valid_out, byte_strobe, active;
  int tests = 0, fails = 0;
  typedef struct {
    logic [7:0] byte_in;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_active;
  } vec_t;
  vec_t vecs[8];

  s2p_com_align #(.COM_COUNT(4), .LOSS_COUNT(4)) dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out),
    .byte_strobe(byte_strobe), .active(active)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clk_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  // sends a byte MSB first; no strobe is allowed on the first 7 bits
  task automatic send_byte(input logic [7:0] b);
    int mid = 0;
    for (int i = 7; i > 0; i--) begin
      clk_bit(b[i]);
      if (byte_strobe) mid++;
    end
    chk("mid_strobe", mid, 0);
    clk_bit(b[0]);
  endtask

  task automatic chk_out(input string name, input logic [7:0] d, input logic v,
                         input logic s, input logic a);
    chk({name, "_data"}, {24'd0, data_out}, {24'd0, d});
    chk({name, "_valid"}, {31'd0, valid_out}, {31'd0, v});
    chk({name, "_strobe"}, {31'd0, byte_strobe}, {31'd0, s});
    chk({name, "_active"}, {31'd0, active}, {31'd0, a});
  endtask

  initial begin
    vecs[0] = '{8'h55, 8'h55, 1'b1, 1'b1};
    vecs[1] = '{8'hA7, 8'hA7, 1'b1, 1'b1};
    vecs[2] = '{8'hBC, 8'hBC, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b1};
`ifdef S2P_LOSS_DETECT_EN
    vecs[6] = '{8'h01, 8'h01, 1'b1, 1'b1};
`else
    vecs[6] = '{8'h00, 8'h00, 1'b1, 1'b1};
`endif
    vecs[7] = '{8'h3C, 8'h3C, 1'b1, 1'b1};

    reset = 1'b1;
    clk_bit(1'b1);
    clk_bit(1'b0);
    chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    clk_bit(1'b0);
    clk_bit(1'b1);
    clk_bit(1'b0);
    for (int k = 0; k < 3; k++) begin
      send_byte(8'hBC);
      chk_out("lock_pre", 8'h00, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 7; i > 0; i--) clk_bit(1'(8'hBC >> i));
    chk("edge34_active", {31'd0, active}, 32'd0);
    clk_bit(1'b0);
    chk_out("edge35", 8'h00, 1'b0, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      send_byte(vecs[i].byte_in);
      chk_out($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid, 1'b1, vecs[i].exp_active);
    end
    clk_bit(1'b1);
    chk_out("after_strobe", 8'h3C, 1'b1, 1'b0, 1'b1);

    clk_bit(1'b0);
    clk_bit(1'b1);
    reset = 1'b1;
    clk_bit(1'b1);
    chk_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int k = 0; k < 3; k++) begin
      send_byte(8'hBC);
      chk_out("relock_pre", 8'h00, 1'b0, 1'b0, 1'b0);
    end
    send_byte(8'h12);
    chk_out("lock_abort", 8'h00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      send_byte(8'hBC);
      chk("relock_wait", {31'd0, active}, 32'd0);
    end
    send_byte(8'hBC);
    chk_out("relock", 8'h00, 1'b0, 1'b0, 1'b1);
    send_byte(8'h5A);
    chk_out("relock_pay", 8'h5A, 1'b1, 1'b1, 1'b1);

`ifdef S2P_LOSS_DETECT_EN
    for (int k = 0; k < 3; k++) begin
      send_byte(8'h00);
      chk_out("loss_pre", 8'h00, 1'b1, 1'b1, 1'b1);
    end
    send_byte(8'h00);
    chk_out("loss", 8'h00, 1'b0, 1'b1, 1'b0);
    clk_bit(1'b0);
    chk_out("loss_after", 8'h00, 1'b0, 1'b0, 1'b0);
`else
    for (int k = 0; k < 5; k++) begin
      send_byte(8'h00);
      chk_out("sticky", 8'h00, 1'b1, 1'b1, 1'b1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
